// File: rtl/alu_muldiv_unit_if.sv
// alu_muldiv_unit_if: request/result bundle between a requester and alu_muldiv_unit.
interface alu_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready_out;
    logic             valid_out;
    logic [WIDTH-1:0] ALUresult;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid_in, ALUOp, a, b,
        input  ready_out, valid_out, ALUresult, zero, hi, lo
    );
    modport slave (
        input  valid_in, ALUOp, a, b,
        output ready_out, valid_out, ALUresult, zero, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: single-cycle ALU plus iterative multu and, with ALU_MULDIV_DIV_EN, divu.
// acc holds {product high, multiplier} for multu and {remainder, quotient} for divu.
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic clk,
    input logic reset_n,
    alu_muldiv_unit_if.slave bus
);
`ifdef ALU_MULDIV_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif
    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0]   opnd, result, hi, lo, sc_res;
    logic [WIDTH:0]     mul_sum;
    logic               zero, valid_out, accept, multi, last;

    assign accept  = bus.valid_in && state == IDLE;
    assign last    = cnt == CNT_W'(WIDTH - 1);
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
`ifdef ALU_MULDIV_DIV_EN
    logic [WIDTH:0] div_diff;
    assign multi    = bus.ALUOp == 4'b0101 || bus.ALUOp == 4'b1101;
    assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    // Restoring step: keep the shifted partial remainder when the trial subtract borrows.
    assign acc_nx   = state != DIV ? {mul_sum, acc[WIDTH-1:1]} :
                      div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
                      {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`else
    assign multi  = bus.ALUOp == 4'b0101;
    assign acc_nx = {mul_sum, acc[WIDTH-1:1]};
`endif

    always_comb begin
        sc_res = '0;
        case (bus.ALUOp)
            4'b0001, 4'b1011, 4'b1100: sc_res = bus.a + bus.b;
            4'b0010: sc_res = bus.a - bus.b;
            4'b0011: sc_res = bus.a & bus.b;
            4'b0100: sc_res = bus.a | bus.b;
            4'b0110: sc_res = bus.a ^ bus.b;
            4'b0111: sc_res = ~(bus.a | bus.b);
            4'b1000: sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            4'b1001: sc_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            4'b1110: sc_res = hi;
            4'b1111: sc_res = lo;
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
`ifdef ALU_MULDIV_DIV_EN
            IDLE:    state_nx = accept && multi ? (bus.ALUOp[3] ? DIV : MUL) : IDLE;
`else
            IDLE:    state_nx = accept && multi ? MUL : IDLE;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = last ? DONE : state;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            result    <= '0;
            zero      <= 1'b1;
            valid_out <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            valid_out <= 1'b0;
            if (accept && multi) begin
                acc  <= {{WIDTH{1'b0}}, bus.a};
                opnd <= bus.b;
                cnt  <= '0;
            end else if (accept) begin
                result    <= sc_res;
                zero      <= sc_res == '0;
                valid_out <= 1'b1;
            end else if (state == DONE) begin
                {hi, lo}  <= acc;
                result    <= acc[WIDTH-1:0];
                zero      <= acc[WIDTH-1:0] == '0;
                valid_out <= 1'b1;
            end else if (state != IDLE) begin
                acc <= acc_nx;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ready_out = state == IDLE;
    assign bus.valid_out = valid_out;
    assign bus.ALUresult = result;
    assign bus.zero      = zero;
    assign bus.hi        = hi;
    assign bus.lo        = lo;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed-vector bench for alu_muldiv_unit at WIDTH=32.
module tb_alu_muldiv_unit;
    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_muldiv_unit_if #(.WIDTH(32)) bus ();

    alu_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for one edge; returns at edge+1.
    task automatic op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.valid_in = 1'b1;
        bus.ALUOp    = o;
        bus.a        = x;
        bus.b        = y;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
    endtask

    // Start a multi-cycle op and wait (bounded) for valid_out; optionally keep a
    // conflicting add request and scrambled operands on the bus while busy.
    task automatic run_multi(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                             input bit hold, output int lat, output int busy);
        op(o, x, y);
        if (hold) begin
            bus.valid_in = 1'b1;
            bus.ALUOp    = 4'b0001;
            bus.a        = 32'h1234_5678;
            bus.b        = 32'h0BAD_F00D;
        end
        lat  = -1;
        busy = 0;
        for (int i = 1; i <= 100; i++) begin
            if (bus.valid_out) begin
                lat = i;
                bus.valid_in = 1'b0;
                break;
            end
            if (!bus.ready_out) busy++;
            @(posedge clk); #1;
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.ready_out); end
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
        n_cmp++; if (bus.ALUresult !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.ALUresult); end
        n_cmp++; if (bus.zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b want 1", bus.zero); end
        n_cmp++; if ({bus.hi, bus.lo} !== 64'h0) begin n_err++; $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo}); end
    endtask

    task automatic test_single();
        logic [3:0]  ops [14] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1000,
                                  4'b1001, 4'b1000, 4'b1001, 4'b1011, 4'b1100, 4'b0000, 4'b1010};
        logic [31:0] xa  [14] = '{32'hFFFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h00FF00FF,
                                  32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1, 32'd1, 32'h1000, 32'hFFFFFFF0, 32'd5, 32'd9};
        logic [31:0] xb  [14] = '{32'd1, 32'd7, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F, 32'h0000FFFF,
                                  32'd1, 32'd1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd4, 32'h20, 32'd5, 32'd3};
        logic [31:0] exp [14] = '{32'h0, 32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F, 32'hFF000000,
                                  32'd1, 32'd0, 32'd0, 32'd1, 32'h1004, 32'h10, 32'h0, 32'h0};
        for (int i = 0; i < 14; i++) begin
            op(ops[i], xa[i], xb[i]);
            n_cmp++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d]: got %b want 1", i, bus.valid_out); end
            n_cmp++; if (bus.ALUresult !== exp[i]) begin n_err++; $display("FAIL single_result[%0d]: got %h want %h", i, bus.ALUresult, exp[i]); end
            n_cmp++; if (bus.zero !== (exp[i] == 32'h0)) begin n_err++; $display("FAIL single_zero[%0d]: got %b want %b", i, bus.zero, exp[i] == 32'h0); end
            n_cmp++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL single_ready[%0d]: got %b want 1", i, bus.ready_out); end
            @(posedge clk); #1;
            n_cmp++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL single_pulse[%0d]: got %b want 0", i, bus.valid_out); end
        end
    endtask

    task automatic test_back_to_back();
        bus.valid_in = 1'b1; bus.ALUOp = 4'b0001; bus.a = 32'd1; bus.b = 32'd2;
        @(posedge clk); #1;
        n_cmp++; if ({bus.valid_out, bus.ALUresult} !== {1'b1, 32'd3}) begin n_err++; $display("FAIL b2b_first: got %b/%h want 1/3", bus.valid_out, bus.ALUresult); end
        bus.ALUOp = 4'b0010; bus.a = 32'd10; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        n_cmp++; if ({bus.valid_out, bus.ALUresult} !== {1'b1, 32'd7}) begin n_err++; $display("FAIL b2b_second: got %b/%h want 1/7", bus.valid_out, bus.ALUresult); end
        @(posedge clk); #1;
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", bus.valid_out); end
    endtask

    task automatic test_multu();
        int lat, busy;
        run_multi(4'b0101, 32'hFFFFFFFF, 32'd2, 1'b1, lat, busy);
        n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL mul_latency: got %0d want 34", lat); end
        n_cmp++; if (busy !== 33) begin n_err++; $display("FAIL mul_busy: got %0d want 33", busy); end
        n_cmp++; if (bus.hi !== 32'd1) begin n_err++; $display("FAIL mul_hi: got %h want 1", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mul_lo: got %h want fffffffe", bus.lo); end
        n_cmp++; if ({bus.ALUresult, bus.zero} !== {32'hFFFFFFFE, 1'b0}) begin n_err++; $display("FAIL mul_result: got %h/%b want fffffffe/0", bus.ALUresult, bus.zero); end
        @(posedge clk); #1;
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL mul_pulse: got %b want 0", bus.valid_out); end
        op(4'b1110, 32'd0, 32'd0);
        n_cmp++; if (bus.ALUresult !== 32'd1) begin n_err++; $display("FAIL mfhi: got %h want 1", bus.ALUresult); end
        op(4'b1111, 32'd0, 32'd0);
        n_cmp++; if (bus.ALUresult !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mflo: got %h want fffffffe", bus.ALUresult); end
        run_multi(4'b0101, 32'h80000000, 32'd4, 1'b0, lat, busy);
        n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL mul2_latency: got %0d want 34", lat); end
        n_cmp++; if ({bus.hi, bus.lo} !== 64'h2_00000000) begin n_err++; $display("FAIL mul2_hilo: got %h want 200000000", {bus.hi, bus.lo}); end
        n_cmp++; if ({bus.ALUresult, bus.zero} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL mul2_zero: got %h/%b want 0/1", bus.ALUresult, bus.zero); end
    endtask

    task automatic test_divu();
`ifdef ALU_MULDIV_DIV_EN
        int lat, busy;
        run_multi(4'b1101, 32'd100, 32'd7, 1'b1, lat, busy);
        n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL div_latency: got %0d want 34", lat); end
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL div_hilo: got %h/%h want 2/e", bus.hi, bus.lo); end
        n_cmp++; if (bus.ALUresult !== 32'd14) begin n_err++; $display("FAIL div_result: got %h want e", bus.ALUresult); end
        run_multi(4'b1101, 32'd5, 32'd0, 1'b0, lat, busy);
        n_cmp++; if ({bus.hi, bus.lo} !== {32'd5, 32'hFFFFFFFF}) begin n_err++; $display("FAIL div0_hilo: got %h/%h want 5/ffffffff", bus.hi, bus.lo); end
`else
        op(4'b1101, 32'd100, 32'd7);
        n_cmp++; if ({bus.valid_out, bus.ALUresult, bus.zero} !== {1'b1, 32'h0, 1'b1}) begin n_err++; $display("FAIL nodiv_result: got %b/%h/%b want 1/0/1", bus.valid_out, bus.ALUresult, bus.zero); end
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL nodiv_ready: got %b want 1", bus.ready_out); end
        n_cmp++; if ({bus.hi, bus.lo} !== 64'h2_00000000) begin n_err++; $display("FAIL nodiv_hilo: got %h want 200000000", {bus.hi, bus.lo}); end
`endif
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        logic [63:0] prev;
        prev = {bus.hi, bus.lo};
        op(4'b0101, 32'hFFFFFFFF, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        n_cmp++; if (bus.ready_out !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.ready_out); end
        n_cmp++; if ({bus.hi, bus.lo} !== prev) begin n_err++; $display("FAIL abort_hilo_hold: got %h want %h", {bus.hi, bus.lo}, prev); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", bus.ready_out); end
        n_cmp++; if ({bus.hi, bus.lo} !== 64'h0) begin n_err++; $display("FAIL abort_hilo: got %h want 0", {bus.hi, bus.lo}); end
        n_cmp++; if ({bus.ALUresult, bus.zero} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL abort_result: got %h/%b want 0/1", bus.ALUresult, bus.zero); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_out) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_novalid: got %0d pulses want 0", seen); end
        op(4'b0001, 32'd2, 32'd3);
        n_cmp++; if ({bus.valid_out, bus.ALUresult} !== {1'b1, 32'd5}) begin n_err++; $display("FAIL abort_next_add: got %b/%h want 1/5", bus.valid_out, bus.ALUresult); end
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.valid_in = 1'b0;
        bus.ALUOp    = 4'b0000;
        bus.a        = '0;
        bus.b        = '0;
        repeat (2) begin @(posedge clk); #1; end
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_single();
        test_back_to_back();
        test_multu();
        test_divu();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_unit.md
ALU_MULDIV_UNIT -- requirements
Module: alu_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width in bits (legal 8..64).
REQ-002 SHALL have parameter CNT_W, default 6, the iteration-counter width (2**CNT_W > WIDTH).
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have valid_in  input  1  operation request, qualified by ready_out.
REQ-006 SHALL have ALUOp  input  4  operation code.
REQ-007 SHALL have a, b  input  WIDTH  operands.
REQ-008 SHALL have ready_out  output  1  high when a request can be accepted.
REQ-009 SHALL have valid_out  output  1  one-cycle pulse when ALUresult/zero are valid.
REQ-010 SHALL have ALUresult  output  WIDTH  registered result.
REQ-011 SHALL have zero  output  1  registered (ALUresult == 0) flag, valid with valid_out.
REQ-012 SHALL have hi, lo  output  WIDTH  HI/LO architectural registers.

Function
REQ-013 Accept SHALL occur on a rising edge with valid_in=1 and ready_out=1; valid_in with ready_out=0 SHALL be ignored, no queueing.
REQ-014 Opcodes: 0001 add, 0010 sub, 0011 and, 0100 or, 0110 xor, 0111 nor, 1000 slt (signed), 1001 sltu, 1011 lw-add, 1100 sw-add, 1110 mfhi, 1111 mflo: single-cycle class.
REQ-015 Opcodes 0101 multu and 1101 divu: multi-cycle class; every other code SHALL return 0 in single-cycle class.
REQ-016 Add/sub SHALL wrap modulo 2**WIDTH; slt/sltu SHALL return {WIDTH-1 zeros, flag}.
REQ-017 Single-cycle class: valid_out SHALL pulse the cycle after accept with result registered; ready_out stays 1, back-to-back accepts allowed.
REQ-018 FSM states IDLE, MUL, DIV, DONE; IDLE->MUL on multu accept, IDLE->DIV on divu accept, MUL/DIV->DONE after exactly WIDTH iterations, DONE->IDLE unconditionally.
REQ-019 ready_out SHALL be 1 only in IDLE.
REQ-020 multu: unsigned shift-add, one bit per cycle; in DONE {hi,lo} SHALL take the 2*WIDTH product, ALUresult = low word, valid_out pulses; latency WIDTH+2 cycles accept-to-valid_out.
REQ-021 divu: unsigned restoring, one bit per cycle; in DONE lo = quotient, hi = remainder, ALUresult = quotient; same latency as multu.
REQ-022 Divide by zero SHALL yield lo = all ones, hi = a, no exception.
REQ-023 mfhi/mflo SHALL return current hi/lo; hi/lo change only in DONE of multu/divu.
REQ-024 Operands SHALL be captured at accept; input changes during MUL/DIV SHALL not affect the result.
REQ-025 valid_out SHALL be 0 in all cycles other than those in REQ-017/020/021.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, ALUresult=0, zero=1, valid_out=0, hi=0, lo=0, counter=0; ready_out=1.
REQ-027 Reset during MUL/DIV SHALL abort the operation with no valid_out and hi/lo cleared.

Configuration
REQ-028 Macro ALU_MULDIV_DIV_EN defined: divu implemented per REQ-021/022.
REQ-029 Macro ALU_MULDIV_DIV_EN undefined: no divider logic; 1101 SHALL behave as single-cycle class returning 0, hi/lo unchanged, DIV state absent.

Verification
REQ-030 WIDTH=32, add a=0xFFFFFFFF b=1 -> next cycle valid_out=1, ALUresult=0, zero=1.
REQ-031 slt a=0xFFFFFFFE(-2) b=1 -> ALUresult=1; sltu same operands -> ALUresult=0.
REQ-032 multu a=0xFFFFFFFF b=2 -> ready_out low 33 cycles, valid_out at cycle 34, hi=1, lo=0xFFFFFFFE; then mfhi -> 1.
REQ-033 divu (DIV_EN) a=100 b=7 -> lo=14, hi=2; a=5 b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-034 valid_in held high during multu busy with add op -> ignored, no extra valid_out.
REQ-035 reset_n low mid-multu (cycle 10) -> ready_out=1, hi=lo=0, no valid_out; next add accepted normally.
